// File: rtl/wb_lsu_master_pkg.sv
// Shared definitions for the Wishbone load/store initiator: funct3 encodings,
// completion causes, FSM states and the byte-lane helpers.
package wb_lsu_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_OK       = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_BUS_ERR  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } lsu_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } lsu_state_e;

  // Unsigned variants exist only for loads; word and half need natural alignment.
  function automatic logic lsu_access_ok(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_lane_sel(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] sel;
    case (funct3[1:0])
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lsu_store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] dat;
    case (funct3[1:0])
      2'b00:   dat = {4{wdata[7:0]}};
      2'b01:   dat = {2{wdata[15:0]}};
      default: dat = wdata;
    endcase
    return dat;
  endfunction

endpackage

// File: rtl/wb_lsu_master_if.sv
// Wishbone B4 classic data-bus signals (dwb_*), seen from the initiator and the responder.
interface wb_lsu_master_if;
  logic [31:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic        dwb_err_i;

  modport master (
    output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
    input  dwb_dat_i, dwb_ack_i, dwb_err_i
  );

  modport slave (
    input  dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
    output dwb_dat_i, dwb_ack_i, dwb_err_i
  );
endinterface

// File: rtl/wb_lsu_master_load_align.sv
// Load data alignment: picks the byte/half at the given offset and extends it.
// Purely combinational so the core writeback path can reuse it.
module lsu_load_align
  import wb_lsu_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    data   = '0;
    byte_v = word[{offset, 3'b000} +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, byte_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic initiator for the core load/store path: one request at a time,
// registered bus outputs, ack/err/timeout termination and a one-cycle response pulse.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_cause,
  wb_lsu_master_if.master dwb
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      load_data;
  logic             timed_out;

  // dat_i is only meaningful in the ack cycle, so alignment works straight off the bus.
  lsu_load_align u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (dwb.dwb_dat_i),
    .data   (load_data)
  );

  assign timed_out     = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign dwb.dwb_stb_o = dwb.dwb_cyc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_cause     <= CAUSE_OK;
      dwb.dwb_adr_o <= '0;
      dwb.dwb_dat_o <= '0;
      dwb.dwb_sel_o <= '0;
      dwb.dwb_we_o  <= 1'b0;
      dwb.dwb_cyc_o <= 1'b0;
    end else begin
      // NOTE: state and outputs update with <= so every branch sees the pre-edge values.
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            req_ready <= 1'b0;
            if (lsu_access_ok(req_we, req_funct3, req_addr[1:0])) begin
              state         <= ST_BUS;
              cnt           <= '0;
              dwb.dwb_cyc_o <= 1'b1;
              dwb.dwb_we_o  <= req_we;
              dwb.dwb_adr_o <= {req_addr[31:2], 2'b00};
              dwb.dwb_sel_o <= lsu_lane_sel(req_funct3, req_addr[1:0]);
              dwb.dwb_dat_o <= lsu_store_data(req_funct3, req_wdata);
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_cause <= CAUSE_MISALIGN;
              rsp_rdata <= '0;
            end
          end
        end

        ST_BUS: begin
          cnt <= cnt + CNT_W'(1);
          if (dwb.dwb_err_i || dwb.dwb_ack_i || timed_out) begin
            state         <= ST_RESP;
            rsp_valid     <= 1'b1;
            dwb.dwb_cyc_o <= 1'b0;
            dwb.dwb_we_o  <= 1'b0;
            dwb.dwb_sel_o <= '0;
            dwb.dwb_adr_o <= '0;
            dwb.dwb_dat_o <= '0;
            // Error beats a simultaneous ack; an ack beats the timeout firing that cycle.
            if (dwb.dwb_err_i) begin
              rsp_cause <= CAUSE_BUS_ERR;
              rsp_rdata <= '0;
            end else if (dwb.dwb_ack_i) begin
              rsp_cause <= CAUSE_OK;
              rsp_rdata <= we_q ? '0 : load_data;
            end else begin
              rsp_cause <= CAUSE_TIMEOUT;
              rsp_rdata <= '0;
            end
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_cause <= CAUSE_OK;
          req_ready <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Bench for wb_lsu_master: word-addressed memory responder with a registered ack,
// directed vector table, randomized accesses against a byte-level model, and reset abort.
module tb_wb_lsu_master;

  localparam int M_OK  = 0;
  localparam int M_ERR = 1;
  localparam int M_SIL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;

  int n_vec = 0;
  int n_bad = 0;
  int mode  = M_OK;

  wb_lsu_master_if bus ();

  wb_lsu_master #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_cause  (rsp_cause),
    .dwb        (bus)
  );

  always #5 clk = ~clk;

  // Responder: ack (and err in error mode) registered one cycle after cyc rises.
  logic [31:0] mem [4096];
  logic        ack_r = 1'b0;
  logic        err_r = 1'b0;

  assign bus.dwb_ack_i = ack_r;
  assign bus.dwb_err_i = err_r;
  assign bus.dwb_dat_i = mem[bus.dwb_adr_o[13:2]];

  always @(posedge clk) begin
    if (bus.dwb_cyc_o && bus.dwb_stb_o && ack_r && !err_r && bus.dwb_we_o)
      for (int i = 0; i < 4; i++)
        if (bus.dwb_sel_o[i]) mem[bus.dwb_adr_o[13:2]][8*i +: 8] <= bus.dwb_dat_o[8*i +: 8];
    if (bus.dwb_cyc_o && !ack_r && !err_r && mode != M_SIL) begin
      ack_r <= 1'b1;
      err_r <= (mode == M_ERR);
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request and watches the bus until the response pulse (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [1:0] cause, output int lat, output int cyc_cnt,
                        output logic [31:0] adr, output logic [3:0] sel,
                        output logic [31:0] dat, output logic bwe, output logic stable);
    rdata = '0; cause = '0; lat = -1; cyc_cnt = 0;
    adr = '0; sel = '0; dat = '0; bwe = 1'b0; stable = 1'b1;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.dwb_stb_o !== bus.dwb_cyc_o) stable = 1'b0;
      if (bus.dwb_cyc_o) begin
        if (cyc_cnt == 0) begin
          adr = bus.dwb_adr_o; sel = bus.dwb_sel_o; dat = bus.dwb_dat_o; bwe = bus.dwb_we_o;
        end else if (adr !== bus.dwb_adr_o || sel !== bus.dwb_sel_o ||
                     dat !== bus.dwb_dat_o || bwe !== bus.dwb_we_o) begin
          stable = 1'b0;
        end
        cyc_cnt++;
      end
      if (rsp_valid) begin
        rdata = rsp_rdata; cause = rsp_cause; lat = n;
        break;
      end
    end
  endtask

  // Reference: the access as byte arithmetic on a word, straight from the ISA rules.
  function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] word,
                                     output logic [1:0] cause, output logic [31:0] rdata,
                                     output logic [3:0] sel, output logic [31:0] dat,
                                     output logic [31:0] new_word);
    int nbytes;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    logic bad;
    nbytes = 1 << f3[1:0];
    off    = int'(addr[1:0]);
    mask   = (64'd1 << (8 * nbytes)) - 64'd1;
    bad    = (f3[1:0] == 2'd3) || (we && f3[2]) || (f3[2] && f3[1:0] == 2'd2) || (off % nbytes != 0);
    cause  = bad ? 2'd1 : 2'd0;
    sel    = 4'(((1 << nbytes) - 1) << off);
    dat    = (nbytes == 4) ? wdata : 32'((64'(wdata) & mask) * (64'hFFFF_FFFF / mask));
    for (int i = 0; i < 4; i++) new_word[8*i +: 8] = sel[i] ? dat[8*i +: 8] : word[8*i +: 8];
    v = (64'(word) >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
    rdata = (we || bad) ? 32'd0 : v[31:0];
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          mode;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_cause;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    int          exp_cyc;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int md, input logic [31:0] rd,
                              input logic [1:0] cs, input logic [3:0] sl, input logic [31:0] dt,
                              input int cy, input int lt);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mode = md;
    v.exp_rdata = rd; v.exp_cause = cs; v.exp_sel = sl; v.exp_dat = dt;
    v.exp_cyc = cy; v.exp_lat = lt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[$];
    logic [31:0] rd, adr, dat, ew, er, ed, nw;
    logic [1:0]  cs, ec;
    logic [3:0]  sl, es;
    logic        bwe, stb_ok;
    int          lat, cyc;
    logic [31:0] model_mem [16];
    int          seen;

    // Reset values.
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset cyc", 32'(bus.dwb_cyc_o), 32'd0);
    check("reset stb", 32'(bus.dwb_stb_o), 32'd0);
    check("reset we/sel", {27'd0, bus.dwb_we_o, bus.dwb_sel_o}, 32'd0);
    check("reset adr", bus.dwb_adr_o, 32'd0);
    check("reset dat", bus.dwb_dat_o, 32'd0);
    check("reset rdata/cause", rsp_rdata ^ 32'(rsp_cause), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vt.push_back(mk(1, 3'b010, 32'h1000, 32'hDEADBEEF, M_OK, 32'h0,        2'd0, 4'hF, 32'hDEADBEEF, 2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1000, 32'h0,        M_OK, 32'hDEADBEEF, 2'd0, 4'hF, 32'h0,        2, 3));
    vt.push_back(mk(1, 3'b010, 32'h1000, 32'h80FF1234, M_OK, 32'h0,        2'd0, 4'hF, 32'h80FF1234, 2, 3));
    vt.push_back(mk(0, 3'b000, 32'h1003, 32'h0,        M_OK, 32'hFFFFFF80, 2'd0, 4'h8, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b100, 32'h1003, 32'h0,        M_OK, 32'h00000080, 2'd0, 4'h8, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b101, 32'h1002, 32'h0,        M_OK, 32'h000080FF, 2'd0, 4'hC, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b001, 32'h1002, 32'h0,        M_OK, 32'hFFFF80FF, 2'd0, 4'hC, 32'h0,        2, 3));
    vt.push_back(mk(1, 3'b001, 32'h1002, 32'h0000ABCD, M_OK, 32'h0,        2'd0, 4'hC, 32'hABCDABCD, 2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1000, 32'h0,        M_OK, 32'hABCD1234, 2'd0, 4'hF, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1001, 32'h0,        M_OK, 32'h0,        2'd1, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(1, 3'b001, 32'h1003, 32'h1234,     M_OK, 32'h0,        2'd1, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(1, 3'b000, 32'h1001, 32'h0000005A, M_OK, 32'h0,        2'd0, 4'h2, 32'h5A5A5A5A, 2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1000, 32'h0,        M_OK, 32'hABCD5A34, 2'd0, 4'hF, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b011, 32'h1000, 32'h0,        M_OK, 32'h0,        2'd1, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(1, 3'b100, 32'h1000, 32'h77,       M_OK, 32'h0,        2'd1, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'b110, 32'h1000, 32'h0,        M_OK, 32'h0,        2'd1, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(1, 3'b010, 32'h1000, 32'h11111111, M_ERR, 32'h0,       2'd2, 4'hF, 32'h11111111, 2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1000, 32'h0,        M_OK, 32'hABCD5A34, 2'd0, 4'hF, 32'h0,        2, 3));
    vt.push_back(mk(0, 3'b010, 32'h1000, 32'h0,        M_SIL, 32'h0,       2'd3, 4'hF, 32'h0,       16, 17));
    vt.push_back(mk(0, 3'b000, 32'h1000, 32'h0,        M_ERR, 32'h0,       2'd2, 4'h1, 32'h0,        2, 3));

    foreach (vt[i]) begin
      mode = vt[i].mode;
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, cs, lat, cyc, adr, sl, dat, bwe, stb_ok);
      check($sformatf("v%0d cause", i), 32'(cs), 32'(vt[i].exp_cause));
      check($sformatf("v%0d rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("v%0d rsp latency", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("v%0d cyc cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
      check($sformatf("v%0d bus stable", i), 32'(stb_ok), 32'd1);
      if (vt[i].exp_cyc > 0) begin
        check($sformatf("v%0d adr", i), adr, {vt[i].addr[31:2], 2'b00});
        check($sformatf("v%0d sel", i), 32'(sl), 32'(vt[i].exp_sel));
        check($sformatf("v%0d we", i), 32'(bwe), 32'(vt[i].we));
        if (vt[i].we) check($sformatf("v%0d dat", i), dat, vt[i].exp_dat);
      end
    end

    // Randomized phase over a 16-word window, seeded through the bus.
    mode = M_OK;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      do_req(1'b1, 3'b010, 32'h2000 + 32'(4 * i), model_mem[i], rd, cs, lat, cyc, adr, sl, dat, bwe, stb_ok);
      check($sformatf("seed%0d cause", i), 32'(cs), 32'd0);
    end
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      int          idx;
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = 32'h2000 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      idx  = int'(addr[5:2]);
      mode = ($urandom_range(0, 9) == 0) ? M_ERR : M_OK;
      ref_access(we, f3, addr, wd, model_mem[idx], ec, er, es, ed, nw);
      if (ec == 2'd0 && mode == M_ERR) begin
        ec = 2'd2;
        er = 32'd0;
      end
      do_req(we, f3, addr, wd, rd, cs, lat, cyc, adr, sl, dat, bwe, stb_ok);
      check($sformatf("r%0d cause", i), 32'(cs), 32'(ec));
      check($sformatf("r%0d rdata", i), rd, er);
      check($sformatf("r%0d latency", i), 32'(lat), (ec == 2'd1) ? 32'd1 : 32'd3);
      if (ec != 2'd1) begin
        check($sformatf("r%0d sel", i), 32'(sl), 32'(es));
        if (we) check($sformatf("r%0d dat", i), dat, ed);
      end
      if (ec == 2'd0 && we) model_mem[idx] = nw;
    end

    // Asynchronous reset in the middle of a bus cycle.
    mode = M_SIL;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset cyc", 32'(bus.dwb_cyc_o), 32'd1);
    check("pre-reset req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort cyc", 32'(bus.dwb_cyc_o), 32'd0);
    check("abort stb", 32'(bus.dwb_stb_o), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = M_OK;
    seen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || bus.dwb_cyc_o) seen++;
    end
    check("no stray rsp after reset", 32'(seen), 32'd0);
    do_req(1'b0, 3'b010, 32'h2000, 32'h0, rd, cs, lat, cyc, adr, sl, dat, bwe, stb_ok);
    check("post-reset load", rd, model_mem[0]);
    check("post-reset cause", 32'(cs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
